rx_frame_packer: RTL and testbench
==================================

# rx_frame_packer

Receive-path stage directly upstream of the rx_controller AXI4-Lite register block. It takes the byte-aligned stream recovered from the VFAT3 link, delimits frames on start/end flags, and packs bytes into 32-bit words. Words are stored in a first-word-fall-through FIFO, which the rx_controller drains through a pop interface on register read. It also keeps a frame counter and sticky error and overflow flags for status registers.

## Interface
- FIFO_DEPTH, 16: word FIFO depth; power of two, at least 4.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- in_byte  in  8  received byte.
- in_valid  in  1  in_byte, in_sof and in_eof are valid this cycle.
- in_sof  in  1  first byte of a frame; qualified by in_valid.
- in_eof  in  1  last byte of a frame; qualified by in_valid. sof and eof may both be set (1-byte frame).
- out_rd  in  1  pop the head word; ignored when out_empty=1.
- out_data  out  32  head word; valid while out_empty=0.
- out_last  out  1  head word is the final word of a frame.
- out_empty  out  1  FIFO empty.
- out_level  out  $clog2(FIFO_DEPTH)+1  number of words stored.
- frame_cnt  out  16  number of frames fully written; wraps 0xFFFF to 0.
- ovf_sticky  out  1  a word was dropped because the FIFO was full.
- err_sticky  out  1  protocol error.
- flag_clr  in  1  clears ovf_sticky and err_sticky.

## Operation
- The packer has three states.
  - IDLE: waits for a frame start.
  - PACK: collecting a frame.
  - DROP: discarding the rest of an overflowed frame.
- Byte lane: byte k of a word goes to bits [8k+7:8k], little-endian. A 2-bit lane index resets to 0 at every sof.
- IDLE:
  - A valid byte with sof is loaded into lane 0 and the state goes to PACK.
  - If that byte also has eof, a 1-byte word is pushed with last=1 and the state stays IDLE.
  - A valid byte without sof is dropped and sets err_sticky.
- PACK:
  - A word is pushed when lane 3 is filled or when the eof byte arrives.
  - Unfilled lanes are 0. last=1 only on the eof word.
  - eof returns the state to IDLE.
- sof while in PACK:
  - The partial word is discarded and err_sticky is set.
  - The new byte starts a fresh frame at lane 0.
  - Words of the aborted frame already in the FIFO stay there, with no last marker.
- Overflow:
  - A push while level==FIFO_DEPTH and out_rd=0 is dropped and sets ovf_sticky.
  - If the dropped word had eof, the state goes to IDLE. Otherwise it goes to DROP.
- DROP:
  - Bytes are discarded until eof (go to IDLE) or sof (handled as in IDLE: starts a new frame).
  - No error is flagged in DROP.
- frame_cnt increments once per accepted last=1 push.
- FIFO storage:
  - 33 bits per entry (data plus last).
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full/empty is derived from the pointers and matches out_level.
- Sticky flags:
  - Set has priority over flag_clr in the same cycle.
  - Each flag stays set until flag_clr or reset.

## Timing
- Reset values: state IDLE, lane 0, FIFO empty (out_empty=1, out_level=0), out_data=0, out_last=0, frame_cnt=0, ovf_sticky=0, err_sticky=0. Any partial word is discarded.
- Reset mid-frame: the next frame requires a fresh sof; the continuing bytes raise err_sticky.
- Input accepts one byte per cycle with no backpressure. in_valid=0 cycles leave the packer state unchanged.
- Push latency: the completing byte is sampled at edge N. The word is written at edge N+1, so out_empty=0 and out_level updates are visible after N+1. Latency is 2 cycles from byte presented to word readable.
- Pop: out_rd sampled high with out_empty=0 advances the head at the edge. The new out_data/out_last are visible the same cycle the edge completes (FWFT).
- Push and pop in the same cycle:
  - Level is unchanged.
  - When full, the push is accepted, because the pop frees the slot.
  - When empty, only the push takes effect.
- out_data holds its last value when empty. Consumers use out_empty.
- frame_cnt and the sticky flags update one edge after the triggering push or byte.

## Test plan
- Bytes 11,22,33,44,55 with sof on 11 and eof on 55 -> FIFO holds 0x44332211 (last=0) then 0x00000055 (last=1). frame_cnt=1 and out_level=2, two cycles after the 55 byte.
- Single byte 0xA5 with sof=eof=1 -> one word 0x000000A5, last=1. frame_cnt=1.
- FIFO_DEPTH=16, 80-byte frame with no reads:
  - 16 words are stored and ovf_sticky=1.
  - The remaining bytes are dropped.
  - The next 4-byte frame is written only after a pop frees space.
  - flag_clr then drives ovf_sticky=0.
- Bytes 01,02 (sof on 01), then sof on 0A, then 0B and 0C with eof on 0C -> err_sticky=1. Only 0x000C0B0A (last=1) is stored. frame_cnt=1.
- With the FIFO full, pop and push a completing byte in the same cycle -> out_level stays 16, ovf_sticky stays 0, and the words read back in order.
- Assert ARESET mid-frame, then send 2 bytes without sof -> FIFO empty, err_sticky=1, frame_cnt=0.

Source files
------------

// File: rtl/rx_frame_packer.sv
// rx_frame_packer
//
// Receive-path stage in front of the rx_controller register block. It
// delimits frames in the recovered VFAT3 byte stream using start/end flags,
// packs bytes little-endian into 32-bit words and stores them with an
// end-of-frame marker in a first-word-fall-through FIFO. The FIFO is drained
// through a pop interface. The block also keeps a frame counter and sticky
// overflow/error flags.
//
// Ports
//   ACLK        clock; all logic is on the rising edge
//   ARESET      synchronous active-high reset
//   in_byte     received byte
//   in_valid    in_byte/in_sof/in_eof are valid this cycle
//   in_sof      first byte of a frame
//   in_eof      last byte of a frame (may coincide with in_sof)
//   out_rd      pop the head word; ignored while out_empty=1
//   out_data    head word; meaningful while out_empty=0, holds when empty
//   out_last    head word is the final word of a frame
//   out_empty   FIFO empty
//   out_level   number of stored words
//   frame_cnt   frames fully written (wraps)
//   ovf_sticky  a word was dropped because the FIFO was full
//   err_sticky  protocol error (byte outside a frame, sof inside a frame)
//   flag_clr    clears both sticky flags; a simultaneous set wins
module rx_frame_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic                        in_eof,
    input  logic                        out_rd,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic                        out_empty,
    output logic [$clog2(FIFO_DEPTH):0] out_level,
    output logic [15:0]                 frame_cnt,
    output logic                        ovf_sticky,
    output logic                        err_sticky,
    input  logic                        flag_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DROP
    } pack_state_t;

    pack_state_t state;
    pack_state_t state_next;
    pack_state_t eff_state;

    logic [1:0]  lane;
    logic [31:0] acc;

    logic        push_q;
    logic        push_last_q;
    logic [31:0] push_data_q;

    logic        start_frame;
    logic        append_byte;
    logic        emit_word;
    logic        emit_last;
    logic        set_err;

    logic [1:0]  lane_sel;
    logic [31:0] byte_word;
    logic [31:0] merged;

    logic [32:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level;
    logic [PW-1:0] next_rd;
    logic [PW-1:0] next_level;
    logic          full;
    logic          empty;
    logic          pop_en;
    logic          push_ok;
    logic          push_drop;
    logic [31:0]   head_data;
    logic          head_last;

    // FIFO occupancy comes straight from the pointer difference, so full,
    // empty and out_level can never disagree.
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == PW'(FIFO_DEPTH));
    assign empty     = (wr_ptr == rd_ptr);
    assign pop_en    = out_rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push_q && (!full || pop_en);
    assign push_drop = push_q && !push_ok;
    assign next_rd    = rd_ptr + PW'(pop_en);
    assign next_level = level + PW'(push_ok) - PW'(pop_en);

    // The word is written one edge after its completing byte, so an overflow
    // is only known then. If the dropped word was not the frame end, the byte
    // arriving in this same cycle must already be treated as being in DROP.
    assign eff_state = (push_drop && !push_last_q) ? S_DROP : state;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cycles without in_valid keep the effective state.
    always_comb begin
        state_next = eff_state;
        if (in_valid) begin
            case (eff_state)
                S_IDLE: begin
                    if (in_sof) begin
                        state_next = in_eof ? S_IDLE : S_PACK;
                    end
                end
                S_PACK: begin
                    state_next = in_eof ? S_IDLE : S_PACK;
                end
                S_DROP: begin
                    if (in_sof) begin
                        state_next = in_eof ? S_IDLE : S_PACK;
                    end else if (in_eof) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Per-byte control decoded from the effective state.
    always_comb begin
        start_frame = 1'b0;
        append_byte = 1'b0;
        emit_word   = 1'b0;
        emit_last   = 1'b0;
        set_err     = 1'b0;
        if (in_valid) begin
            case (eff_state)
                S_IDLE, S_DROP: begin
                    if (in_sof) begin
                        start_frame = 1'b1;
                        emit_word   = in_eof;
                        emit_last   = in_eof;
                    end else if (eff_state == S_IDLE) begin
                        set_err = 1'b1;
                    end
                end
                S_PACK: begin
                    if (in_sof) begin
                        // Abort: the partial word is thrown away.
                        set_err     = 1'b1;
                        start_frame = 1'b1;
                        emit_word   = in_eof;
                        emit_last   = in_eof;
                    end else begin
                        append_byte = 1'b1;
                        emit_word   = in_eof || (lane == 2'd3);
                        emit_last   = in_eof;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte placement: a fresh frame always starts at lane 0 with an empty word.
    assign lane_sel  = start_frame ? 2'd0 : lane;
    assign byte_word = {24'h000000, in_byte} << {lane_sel, 3'b000};
    assign merged    = (start_frame ? 32'h0 : acc) | byte_word;

    // Packing datapath and one-deep push stage towards the FIFO.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            acc         <= 32'h0;
            lane        <= 2'd0;
            push_q      <= 1'b0;
            push_last_q <= 1'b0;
            push_data_q <= 32'h0;
        end else begin
            push_q      <= emit_word;
            push_last_q <= emit_last;
            if (emit_word) begin
                push_data_q <= merged;
                acc         <= 32'h0;
                lane        <= 2'd0;
            end else if (start_frame || append_byte) begin
                acc  <= merged;
                lane <= lane_sel + 2'd1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge ACLK) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {push_last_q, push_data_q};
        end
    end

    // FIFO pointers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Registered head word. It is preloaded with whatever will be at the head
    // after this edge, bypassing the write when the new word becomes the head.
    // When the FIFO goes empty the last head value is simply held.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            head_data <= 32'h0;
            head_last <= 1'b0;
        end else if (next_level != '0) begin
            if (push_ok && (wr_ptr[AW-1:0] == next_rd[AW-1:0])) begin
                head_data <= push_data_q;
                head_last <= push_last_q;
            end else begin
                {head_last, head_data} <= mem[next_rd[AW-1:0]];
            end
        end
    end

    // Frame counter and sticky flags; a set beats a simultaneous clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frame_cnt  <= 16'h0;
            ovf_sticky <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (push_ok && push_last_q) begin
                frame_cnt <= frame_cnt + 16'h1;
            end
            if (push_drop) begin
                ovf_sticky <= 1'b1;
            end else if (flag_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (set_err) begin
                err_sticky <= 1'b1;
            end else if (flag_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    assign out_data  = head_data;
    assign out_last  = head_last;
    assign out_empty = empty;
    assign out_level = level;

endmodule

// File: tb/tb_rx_frame_packer.sv
// tb_rx_frame_packer
//
// Self-checking bench for rx_frame_packer. A driver applies directed and
// random byte/pop traffic and advances a frame-level reference model at each
// edge; the model pushes expected words into a scoreboard queue. A monitor
// compares every word the DUT hands out on a pop against the queue head.
module tb_rx_frame_packer;

    localparam int DEPTH = 16;

    logic        ACLK;
    logic        ARESET;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic        out_rd;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_empty;
    logic [4:0]  out_level;
    logic [15:0] frame_cnt;
    logic        ovf_sticky;
    logic        err_sticky;
    logic        flag_clr;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [32:0] sbq[$];
    logic [7:0]  cur[$];
    int          m_count;
    logic        m_pend;
    logic [32:0] m_pend_word;
    logic        m_in_frame;
    logic        m_dropping;
    logic [15:0] m_frames;
    logic        m_ovf;
    logic        m_err;

    logic [32:0] exp_word;

    rx_frame_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eof     (in_eof),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_empty  (out_empty),
        .out_level  (out_level),
        .frame_cnt  (frame_cnt),
        .ovf_sticky (ovf_sticky),
        .err_sticky (err_sticky),
        .flag_clr   (flag_clr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packs the collected bytes of one word little-endian.
    function automatic logic [31:0] packBytes();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < cur.size(); i++) begin
            w = w | (32'(cur[i]) << (8 * i));
        end
        return w;
    endfunction

    // Advances the model by one clock edge using the inputs just sampled.
    task automatic modelStep();
        logic pop;
        logic set_ovf;
        logic set_err;
        if (ARESET) begin
            sbq.delete();
            cur.delete();
            m_count    = 0;
            m_pend     = 1'b0;
            m_in_frame = 1'b0;
            m_dropping = 1'b0;
            m_frames   = 16'h0;
            m_ovf      = 1'b0;
            m_err      = 1'b0;
            return;
        end
        set_ovf = 1'b0;
        set_err = 1'b0;
        pop = out_rd && (m_count > 0);
        // A word completed on the previous edge reaches the FIFO now.
        if (m_pend) begin
            if (m_count < DEPTH || pop) begin
                sbq.push_back(m_pend_word);
                m_count++;
                if (m_pend_word[32]) m_frames = m_frames + 16'h1;
            end else begin
                set_ovf = 1'b1;
                if (!m_pend_word[32]) begin
                    m_in_frame = 1'b0;
                    m_dropping = 1'b1;
                    cur.delete();
                end
            end
        end
        m_pend = 1'b0;
        if (pop) m_count--;
        if (in_valid) begin
            if (in_sof) begin
                if (m_in_frame) set_err = 1'b1;
                cur.delete();
                cur.push_back(in_byte);
                m_in_frame = 1'b1;
                m_dropping = 1'b0;
            end else if (m_in_frame) begin
                cur.push_back(in_byte);
            end else if (m_dropping) begin
                if (in_eof) m_dropping = 1'b0;
            end else begin
                set_err = 1'b1;
            end
            if (m_in_frame && (in_eof || cur.size() == 4)) begin
                m_pend      = 1'b1;
                m_pend_word = {in_eof, packBytes()};
                cur.delete();
                if (in_eof) m_in_frame = 1'b0;
            end
        end
        m_ovf = set_ovf | (m_ovf & ~flag_clr);
        m_err = set_err | (m_err & ~flag_clr);
    endtask

    // Drives one cycle of inputs, lets the edge happen, then updates the model.
    task automatic applyStimulus(input logic v, input logic s, input logic e,
                                 input logic [7:0] b, input logic rd, input logic clr);
        in_valid = v;
        in_sof   = s;
        in_eof   = e;
        in_byte  = b;
        out_rd   = rd;
        flag_clr = clr;
        @(posedge ACLK);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        ARESET = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        ARESET = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 0, 0);
    endtask

    // Pops until the model says the FIFO is empty, bounded in cycles.
    task automatic drainFifo();
        idleCycles(2);
        for (int i = 0; i < 4 * DEPTH && m_count > 0; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1, 0);
        end
        checkOutput("drain_empty", 33'(out_empty), 33'(1));
        checkOutput("drain_queue", 33'(sbq.size()), 33'(0));
    endtask

    // Monitor: a pop is committed at the next rising edge, so the head word
    // seen mid-cycle is what leaves the FIFO.
    always @(negedge ACLK) begin
        if (!ARESET && out_rd && !out_empty) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_unexpected: got 0x%0h last %0d, expected no word", out_data, out_last);
            end else begin
                exp_word = sbq.pop_front();
                checkOutput("pop_word", {out_last, out_data}, exp_word);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ARESET   = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_byte  = 8'h00;
        out_rd   = 1'b0;
        flag_clr = 1'b0;

        // Reset state.
        doReset();
        checkOutput("rst_empty", 33'(out_empty), 33'(1));
        checkOutput("rst_level", 33'(out_level), 33'(0));
        checkOutput("rst_data", {out_last, out_data}, 33'(0));
        checkOutput("rst_frames", 33'(frame_cnt), 33'(0));
        checkOutput("rst_flags", 33'({ovf_sticky, err_sticky}), 33'(0));

        // Five-byte frame: two words, push latency of two cycles.
        applyStimulus(1, 1, 0, 8'h11, 0, 0);
        applyStimulus(1, 0, 0, 8'h22, 0, 0);
        applyStimulus(1, 0, 0, 8'h33, 0, 0);
        applyStimulus(1, 0, 0, 8'h44, 0, 0);
        applyStimulus(1, 0, 1, 8'h55, 0, 0);
        checkOutput("t1_level_n", 33'(out_level), 33'(1));
        idleCycles(1);
        checkOutput("t1_level_n1", 33'(out_level), 33'(2));
        checkOutput("t1_frames", 33'(frame_cnt), 33'(1));
        checkOutput("t1_head0", {out_last, out_data}, {1'b0, 32'h44332211});
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        checkOutput("t1_head1", {out_last, out_data}, {1'b1, 32'h00000055});
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        checkOutput("t1_empty", 33'(out_empty), 33'(1));
        checkOutput("t1_hold", 33'(out_data), 33'(32'h00000055));

        // Single-byte frame.
        doReset();
        applyStimulus(1, 1, 1, 8'hA5, 0, 0);
        idleCycles(1);
        checkOutput("t2_level", 33'(out_level), 33'(1));
        checkOutput("t2_head", {out_last, out_data}, {1'b1, 32'h000000A5});
        checkOutput("t2_frames", 33'(frame_cnt), 33'(1));
        drainFifo();

        // Overflow: 80-byte frame with no reads.
        doReset();
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1, i == 0, i == 79, 8'(i + 1), 0, 0);
        end
        idleCycles(2);
        checkOutput("t3_level_full", 33'(out_level), 33'(DEPTH));
        checkOutput("t3_ovf", 33'(ovf_sticky), 33'(1));
        checkOutput("t3_frames0", 33'(frame_cnt), 33'(0));
        checkOutput("t3_head", {out_last, out_data}, {1'b0, 32'h04030201});
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        checkOutput("t3_level_pop", 33'(out_level), 33'(DEPTH - 1));
        applyStimulus(1, 1, 0, 8'hC1, 0, 0);
        applyStimulus(1, 0, 0, 8'hC2, 0, 0);
        applyStimulus(1, 0, 0, 8'hC3, 0, 0);
        applyStimulus(1, 0, 1, 8'hC4, 0, 0);
        idleCycles(2);
        checkOutput("t3_level_refill", 33'(out_level), 33'(DEPTH));
        checkOutput("t3_frames1", 33'(frame_cnt), 33'(1));
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        checkOutput("t3_ovf_clr", 33'(ovf_sticky), 33'(0));
        drainFifo();

        // sof inside a frame aborts the partial word.
        doReset();
        applyStimulus(1, 1, 0, 8'h01, 0, 0);
        applyStimulus(1, 0, 0, 8'h02, 0, 0);
        applyStimulus(1, 1, 0, 8'h0A, 0, 0);
        applyStimulus(1, 0, 0, 8'h0B, 0, 0);
        applyStimulus(1, 0, 1, 8'h0C, 0, 0);
        idleCycles(2);
        checkOutput("t4_err", 33'(err_sticky), 33'(1));
        checkOutput("t4_level", 33'(out_level), 33'(1));
        checkOutput("t4_head", {out_last, out_data}, {1'b1, 32'h000C0B0A});
        checkOutput("t4_frames", 33'(frame_cnt), 33'(1));
        drainFifo();

        // Full FIFO with a pop and a push on the same edge.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 1, 1, 8'(8'h30 + i), 0, 0);
        end
        idleCycles(2);
        checkOutput("t5_level_full", 33'(out_level), 33'(DEPTH));
        applyStimulus(1, 1, 1, 8'h99, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        checkOutput("t5_level_same", 33'(out_level), 33'(DEPTH));
        checkOutput("t5_ovf", 33'(ovf_sticky), 33'(0));
        checkOutput("t5_frames", 33'(frame_cnt), 33'(DEPTH + 1));
        drainFifo();

        // Reset in the middle of a frame.
        doReset();
        applyStimulus(1, 1, 0, 8'h11, 0, 0);
        applyStimulus(1, 0, 0, 8'h22, 0, 0);
        doReset();
        applyStimulus(1, 0, 0, 8'h33, 0, 0);
        applyStimulus(1, 0, 0, 8'h44, 0, 0);
        idleCycles(2);
        checkOutput("t6_empty", 33'(out_empty), 33'(1));
        checkOutput("t6_err", 33'(err_sticky), 33'(1));
        checkOutput("t6_frames", 33'(frame_cnt), 33'(0));

        // Random traffic with alternating slow and fast readers.
        doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic v;
            logic s;
            logic e;
            logic rd;
            logic clr;
            v   = ($urandom_range(0, 9) < 7);
            s   = ($urandom_range(0, 9) == 0);
            e   = ($urandom_range(0, 6) == 0);
            rd  = (((cyc / 300) % 3) == 0) ? ($urandom_range(0, 9) == 0)
                                           : ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 49) == 0);
            applyStimulus(v, s, e, 8'($urandom), rd, clr);
            checkOutput("rnd_level", 33'(out_level), 33'(m_count));
            checkOutput("rnd_frames", 33'(frame_cnt), 33'(m_frames));
            checkOutput("rnd_ovf", 33'(ovf_sticky), 33'(m_ovf));
            checkOutput("rnd_err", 33'(err_sticky), 33'(m_err));
        end
        drainFifo();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
